// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// baud divider calculation. Also reused by the matching transmitter.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_t;

  // Clocks per oversample tick, rounded to the nearest integer.
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    int denom;
    denom = baud * oversample;
    return (clk_hz + denom / 2) / denom;
  endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Receiver-side bundle: serial line in, received byte and status out.
// master = the receiver, slave = the line driver / byte consumer.
interface uart_rx_oversampled_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_flag;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    input  rx,
    output rx_data, rx_valid, rx_flag, frame_err, parity_err, busy
  );

  modport slave (
    output rx,
    input  rx_data, rx_valid, rx_flag, frame_err, parity_err, busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks plus the index
// of that tick inside the current bit. A synchronous clear re-phases both
// counters to the start edge.
module uart_baud_tick #(
  parameter int DIV        = 651,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  output logic                          tick,
  output logic [$clog2(OVERSAMPLE)-1:0] tick_idx
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(OVERSAMPLE);

  logic [CW-1:0] div_cnt;

  assign tick = (div_cnt == CW'(DIV - 1));

  // Divider counter, wraps DIV-1 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (clear || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  // Tick index within a bit; holds the number of the tick currently presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tick_idx <= '0;
    else if (clear)
      tick_idx <= '0;
    else if (tick)
      tick_idx <= (tick_idx == IW'(OVERSAMPLE - 1)) ? '0 : tick_idx + 1'b1;
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 16x oversampled 8-bit UART receiver with 2-FF synchroniser, 3-sample
// majority vote, framing check and break handling.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_rx_oversampled_if.master bus
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int IW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int HW  = $clog2(OVERSAMPLE / 2) + 1;

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
    $error("uart_rx_oversampled: OVERSAMPLE must be even and >= 8, PARITY_ODD must be 0 or 1");
  end

  logic [1:0]           sync_ff;
  logic                 s;
  logic                 tick;
  logic [IW-1:0]        tick_idx;
  logic                 tick_clear;
  uart_state_t          state, state_next;
  logic                 v0, v1;
  logic                 maj_point, maj_bit;
  logic                 start_ok, shift_en, frame_good, frame_bad;
  logic [DATA_BITS-1:0] shift_reg;
  logic [BW-1:0]        bit_cnt;
  logic [HW-1:0]        hi_cnt;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, rx_flag_q, frame_err_q;

  uart_baud_tick #(
    .DIV        (DIV),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tick_clear),
    .tick     (tick),
    .tick_idx (tick_idx)
  );

  assign s         = sync_ff[1];
  assign maj_point = tick && (tick_idx == IW'(OVERSAMPLE / 2 + 1));
  assign maj_bit   = (v0 & v1) | (v0 & s) | (v1 & s);

  // Two-stage synchroniser, preset to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sync_ff <= {2{IDLE_LEVEL}};
    else
      sync_ff <= {sync_ff[0], bus.rx};
  end

  // Capture the first two of the three vote samples around mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else if (tick) begin
      if (tick_idx == IW'(OVERSAMPLE / 2 - 1)) v0 <= s;
      if (tick_idx == IW'(OVERSAMPLE / 2))     v1 <= s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic par_en, par_bit, par_mismatch;
  logic parity_err_q;

  assign par_mismatch = (^shift_reg) ^ par_bit ^ PAR_SENSE;
`endif

  // Next-state logic and per-bit strobes for the datapath.
  always_comb begin
    state_next = state;
    tick_clear = 1'b0;
    start_ok   = 1'b0;
    shift_en   = 1'b0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (s != IDLE_LEVEL) begin
          state_next = ST_START;
          tick_clear = 1'b1;
        end
      end
      ST_START: begin
        if (maj_point) begin
          if (maj_bit) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DATA;
            start_ok   = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (maj_point) begin
          shift_en = 1'b1;
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (maj_point) begin
          par_en     = 1'b1;
          state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (maj_point) begin
          if (maj_bit) begin
            frame_good = 1'b1;
            state_next = ST_IDLE;
          end else begin
            frame_bad  = 1'b1;
            state_next = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (tick && s && (hi_cnt == HW'(OVERSAMPLE / 2 - 1)))
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Shift register, counters and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      hi_cnt      <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_flag_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (start_ok) begin
        rx_flag_q <= 1'b0;
        bit_cnt   <= '0;
      end
      if (shift_en) begin
        shift_reg <= {maj_bit, shift_reg[DATA_BITS-1:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (frame_good) begin
        rx_data_q   <= shift_reg;
        rx_valid_q  <= 1'b1;
        rx_flag_q   <= 1'b1;
        frame_err_q <= 1'b0;
      end
      if (frame_bad) begin
        frame_err_q <= 1'b1;
        hi_cnt      <= '0;
      end
      if (state == ST_BREAK && tick)
        hi_cnt <= s ? hi_cnt + 1'b1 : '0;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity bit capture and the sticky parity error, refreshed on each good frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      if (par_en)
        par_bit <= maj_bit;
      if (frame_good)
        parity_err_q <= par_mismatch;
    end
  end

  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_flag   = rx_flag_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled. Runs at a scaled line rate
// (DIV=4, 64 clocks per bit) so full frames stay short. Works with and
// without UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;
  import uart_pkg::*;

  localparam int CLK_HZ   = 100_000_000;
  localparam int BAUD     = 1_562_500;
  localparam int OS       = 16;
  localparam int PODD     = 0;
  localparam int BIT_CLKS = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_oversampled_if bus();

  uart_rx_oversampled #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .PARITY_ODD (PODD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes expected from well-formed frames and the
  // status levels the specification's rules imply.
  logic [7:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;
  logic       exp_flag = 1'b0;
  logic       exp_ferr = 1'b0;
  logic       exp_perr = 1'b0;

  // Monitor: collects every rx_valid pulse and counts frame_err rises.
  logic [7:0] got_q[$];
  int   valid_cnt = 0;
  int   ferr_rise = 0;
  logic ferr_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      got_q.push_back(bus.rx_data);
      valid_cnt++;
    end
    if (bus.frame_err === 1'b1 && ferr_prev !== 1'b1) ferr_rise++;
    ferr_prev = bus.frame_err;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic drive_bit(input logic b, input int n);
    bus.rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_tail(input logic [7:0] d, input logic stop_bit, input int bclk, input logic par_bad);
    logic p;
    for (int i = 0; i < 8; i++) drive_bit(d[i], bclk);
    p = ^d;
    if (PODD != 0) p = ~p;
    if (par_bad) p = ~p;
    if (PAR_EN) drive_bit(p, bclk);
    drive_bit(stop_bit, bclk);
    if (stop_bit) begin
      exp_q.push_back(d);
      exp_data = d;
      exp_flag = 1'b1;
      exp_ferr = 1'b0;
      exp_perr = par_bad & PAR_EN;
    end else begin
      exp_ferr = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bclk, input logic par_bad);
    drive_bit(1'b0, bclk);
    exp_flag = 1'b0;
    send_tail(d, stop_bit, bclk, par_bad);
  endtask

  task automatic test_reset();
    logic [12:0] outv;
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    outv = {bus.rx_data, bus.rx_valid, bus.rx_flag, bus.frame_err, bus.parity_err, bus.busy};
    checks++;
    if (outv !== 13'h0) begin
      errors++;
      $display("[TB] FAIL reset_held: outputs %h expected 0", outv);
    end
    rst_n = 1'b1;
    drive_bit(1'b1, 2 * BIT_CLKS);
    outv = {bus.rx_data, bus.rx_valid, bus.rx_flag, bus.frame_err, bus.parity_err, bus.busy};
    checks++;
    if (outv !== 13'h0 || valid_cnt != 0) begin
      errors++;
      $display("[TB] FAIL reset_idle: outputs %h valids %0d expected 0/0", outv, valid_cnt);
    end
  endtask

  task automatic test_single_byte();
    int v0;
    v0 = valid_cnt;
    got_q.delete();
    send_frame(8'h41, 1'b1, BIT_CLKS, 1'b0);
    drive_bit(1'b1, 8);
    checks++;
    if (valid_cnt - v0 != 1) begin
      errors++;
      $display("[TB] FAIL single_pulses: got %0d expected 1", valid_cnt - v0);
    end
    checks++;
    if (bus.rx_data !== 8'h41 || got_q.size() != 1) begin
      errors++;
      $display("[TB] FAIL single_data: got %h (q %0d) expected 41", bus.rx_data, got_q.size());
    end
    checks++;
    if ({bus.rx_flag, bus.frame_err, bus.busy} !== {exp_flag, exp_ferr, 1'b0}) begin
      errors++;
      $display("[TB] FAIL single_status: flag/ferr/busy %b%b%b expected %b%b0",
               bus.rx_flag, bus.frame_err, bus.busy, exp_flag, exp_ferr);
    end
  endtask

  task automatic test_flag_handshake();
    logic [7:0] d;
    d = 8'($urandom);
    drive_bit(1'b0, 20);
    checks++;
    if (bus.rx_flag !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flag_before_confirm: flag %b busy %b expected 1 1", bus.rx_flag, bus.busy);
    end
    drive_bit(1'b0, BIT_CLKS - 20);
    exp_flag = 1'b0;
    checks++;
    if (bus.rx_flag !== exp_flag) begin
      errors++;
      $display("[TB] FAIL flag_after_confirm: got %b expected %b", bus.rx_flag, exp_flag);
    end
    send_tail(d, 1'b1, BIT_CLKS, 1'b0);
    drive_bit(1'b1, 8);
    checks++;
    if (bus.rx_flag !== exp_flag || bus.rx_data !== exp_data) begin
      errors++;
      $display("[TB] FAIL flag_reset_by_byte: flag %b data %h expected %b %h",
               bus.rx_flag, bus.rx_data, exp_flag, exp_data);
    end
  endtask

  task automatic compare_stream(input string name);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL %s_count: got %0d bytes expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size()) begin
        errors++;
        $display("[TB] FAIL %s_byte%0d: missing expected %h", name, i, exp_q[i]);
      end else if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL %s_byte%0d: got %h expected %h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    seq[0] = 8'h1B;
    seq[1] = 8'h5B;
    seq[2] = 8'h43;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) send_frame(seq[i], 1'b1, BIT_CLKS, 1'b0);
    drive_bit(1'b1, 8);
    compare_stream("b2b");
  endtask

  task automatic test_random_stream();
    int bclk;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 2))
        0:       bclk = 62;
        1:       bclk = 64;
        default: bclk = 66;
      endcase
      send_frame(8'($urandom), 1'b1, bclk, 1'b0);
      drive_bit(1'b1, $urandom_range(0, BIT_CLKS));
    end
    drive_bit(1'b1, 8);
    compare_stream("rand");
  endtask

  task automatic test_glitch();
    int v0;
    v0 = valid_cnt;
    drive_bit(1'b0, 10);
    drive_bit(1'b1, 2 * BIT_CLKS);
    checks++;
    if (valid_cnt != v0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL glitch_reject: valids %0d busy %b expected 0 0", valid_cnt - v0, bus.busy);
    end
    checks++;
    if (bus.rx_flag !== exp_flag || bus.frame_err !== exp_ferr || bus.rx_data !== exp_data) begin
      errors++;
      $display("[TB] FAIL glitch_status: flag %b ferr %b data %h expected %b %b %h",
               bus.rx_flag, bus.frame_err, bus.rx_data, exp_flag, exp_ferr, exp_data);
    end
  endtask

  task automatic test_frame_error();
    int v0, r0;
    logic [7:0] d;
    v0 = valid_cnt;
    send_frame(8'h55, 1'b0, BIT_CLKS, 1'b0);
    drive_bit(1'b1, BIT_CLKS);
    checks++;
    if (bus.frame_err !== 1'b1 || valid_cnt != v0) begin
      errors++;
      $display("[TB] FAIL frame_err_set: ferr %b valids %0d expected 1 0", bus.frame_err, valid_cnt - v0);
    end
    checks++;
    if (bus.rx_data !== exp_data || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL frame_err_hold: data %h busy %b expected %h 0", bus.rx_data, bus.busy, exp_data);
    end
    send_frame(8'h30, 1'b1, BIT_CLKS, 1'b0);
    drive_bit(1'b1, 8);
    checks++;
    if (bus.rx_data !== 8'h30 || bus.frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL frame_err_clear: data %h ferr %b expected 30 0", bus.rx_data, bus.frame_err);
    end
    v0 = valid_cnt;
    r0 = ferr_rise;
    drive_bit(1'b0, 30 * BIT_CLKS);
    exp_flag = 1'b0;
    exp_ferr = 1'b1;
    drive_bit(1'b1, 2 * BIT_CLKS);
    checks++;
    if (ferr_rise - r0 != 1 || valid_cnt != v0 || bus.frame_err !== exp_ferr || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL break: ferr rises %0d valids %0d ferr %b busy %b expected 1 0 1 0",
               ferr_rise - r0, valid_cnt - v0, bus.frame_err, bus.busy);
    end
    d = 8'($urandom);
    send_frame(d, 1'b1, BIT_CLKS, 1'b0);
    drive_bit(1'b1, 8);
    checks++;
    if (bus.rx_data !== d || bus.frame_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL break_recover: data %h ferr %b expected %h 0", bus.rx_data, bus.frame_err, d);
    end
  endtask

  task automatic test_parity();
    int v0;
    v0 = valid_cnt;
    send_frame(8'h07, 1'b1, BIT_CLKS, 1'b1);
    drive_bit(1'b1, 8);
    checks++;
    if (valid_cnt - v0 != 1 || bus.rx_data !== 8'h07 || bus.parity_err !== exp_perr) begin
      errors++;
      $display("[TB] FAIL parity_bad: valids %0d data %h perr %b expected 1 07 %b",
               valid_cnt - v0, bus.rx_data, bus.parity_err, exp_perr);
    end
    send_frame(8'h07, 1'b1, BIT_CLKS, 1'b0);
    drive_bit(1'b1, 8);
    checks++;
    if (bus.parity_err !== exp_perr || bus.rx_data !== 8'h07) begin
      errors++;
      $display("[TB] FAIL parity_good: perr %b data %h expected %b 07", bus.parity_err, bus.rx_data, exp_perr);
    end
  endtask

  task automatic test_baud_offset();
    int v0;
    int rates [2];
    rates[0] = 66;
    rates[1] = 62;
    for (int i = 0; i < 2; i++) begin
      v0 = valid_cnt;
      send_frame(8'hA5, 1'b1, rates[i], 1'b0);
      drive_bit(1'b1, 8);
      checks++;
      if (valid_cnt - v0 != 1 || bus.rx_data !== 8'hA5 || bus.frame_err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL baud_offset_%0d: valids %0d data %h ferr %b expected 1 a5 0",
                 rates[i], valid_cnt - v0, bus.rx_data, bus.frame_err);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [12:0] outv;
    logic [7:0]  d;
    int v0;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, BIT_CLKS);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_frame_busy: got %b expected 1", bus.busy);
    end
    rst_n = 1'b0;
    #1;
    outv = {bus.rx_data, bus.rx_valid, bus.rx_flag, bus.frame_err, bus.parity_err, bus.busy};
    checks++;
    if (outv !== 13'h0) begin
      errors++;
      $display("[TB] FAIL mid_frame_reset: outputs %h expected 0", outv);
    end
    exp_data = 8'h00;
    exp_flag = 1'b0;
    exp_ferr = 1'b0;
    exp_perr = 1'b0;
    bus.rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    v0 = valid_cnt;
    drive_bit(1'b1, 2 * BIT_CLKS);
    d = 8'($urandom);
    send_frame(d, 1'b1, BIT_CLKS, 1'b0);
    drive_bit(1'b1, 8);
    checks++;
    if (valid_cnt - v0 != 1 || bus.rx_data !== d || bus.rx_flag !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_reset_frame: valids %0d data %h flag %b expected 1 %h 1",
               valid_cnt - v0, bus.rx_data, bus.rx_flag, d);
    end
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_single_byte();
    test_flag_handshake();
    test_back_to_back();
    test_random_stream();
    test_glitch();
    test_frame_error();
    test_parity();
    test_baud_offset();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
